// File: rtl/booth_pkg.sv
// Shared constants for the radix-4 Booth digit consumer: digit bit positions,
// the illegal magnitude code, FSM encoding and default operand sizes.
package booth_pkg;

  // Recoded digit bit positions: {c2=two, c1=one, c0=neg}
  localparam int DIG_NEG = 0;
  localparam int DIG_ONE = 1;
  localparam int DIG_TWO = 2;

  // one and two together has no meaning; it is consumed as zero and flagged
  localparam logic [2:0] DIG_ILLEGAL = 3'b110;

  localparam int WIDTH_DEF = 16;
  localparam int NDIG_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/booth_digit_decode.sv
// Combinational Booth digit decode: turns one recoded digit and the signed
// multiplicand into the signed partial product digit*M (WIDTH+2 bits).
module booth_digit_decode
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    neg_i,
  input  logic                    one_i,
  input  logic                    two_i,
  input  logic signed [WIDTH-1:0] m_i,
  output logic signed [WIDTH+1:0] pp_o,
  output logic                    illegal_o
);

  logic [2:0]              code;
  logic                    illegal;
  logic signed [WIDTH+1:0] m_ext;
  logic signed [WIDTH+1:0] mag_pp;

  // Select |digit|*M, then apply the sign; illegal codes contribute zero.
  // Two extra bits cover -2 * most-negative M without overflow.
  always_comb begin
    code          = '0;
    code[DIG_NEG] = neg_i;
    code[DIG_ONE] = one_i;
    code[DIG_TWO] = two_i;
    illegal       = ((code & DIG_ILLEGAL) == DIG_ILLEGAL);
    m_ext         = (WIDTH+2)'(m_i);
    mag_pp        = '0;
    if (!illegal) begin
      if (code[DIG_ONE]) begin
        mag_pp = m_ext;
      end else if (code[DIG_TWO]) begin
        mag_pp = m_ext <<< 1;
      end
    end
    pp_o      = code[DIG_NEG] ? -mag_pp : mag_pp;
    illegal_o = illegal;
  end

endmodule

// File: rtl/booth_digit_accumulator.sv
// Serial radix-4 Booth accumulator: latches M on start, accepts NDIG recoded
// digits LSB first over valid/ready, and presents the PW-bit signed product
// with a one-cycle done pulse.
module booth_digit_accumulator
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NDIG  = NDIG_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic signed [WIDTH-1:0]        multiplicand,
  input  logic                           dig_valid,
  output logic                           dig_ready,
  input  logic                           dig_neg,
  input  logic                           dig_one,
  input  logic                           dig_two,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic signed [WIDTH+2*NDIG-1:0] product
);

  localparam int PW = WIDTH + 2*NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [WIDTH-1:0] m_q, m_d;
  logic signed [PW-1:0]    acc_q, acc_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic                    err_q, err_d;

  logic signed [WIDTH+1:0] pp;
  logic                    pp_illegal;
  logic signed [PW-1:0]    addend;
  logic signed [PW-1:0]    acc_sum;

  booth_digit_decode #(.WIDTH(WIDTH)) u_decode (
    .neg_i     (dig_neg),
    .one_i     (dig_one),
    .two_i     (dig_two),
    .m_i       (m_q),
    .pp_o      (pp),
    .illegal_o (pp_illegal)
  );

  // Weight the partial product by 4^cnt and add it to the running sum.
  always_comb begin
    addend  = PW'(pp) << {cnt_q, 1'b0};
    acc_sum = acc_q + addend;
  end

  // State and datapath registers; reset discards any partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  // Next-state, handshake and accumulate control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    err_d     = err_q;
    dig_ready = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        dig_ready = 1'b1;
        if (dig_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CW'(1);
          if (pp_illegal) begin
            err_d = 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            prod_d  = acc_sum;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign err     = err_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_digit_accumulator.sv
// Directed bench for booth_digit_accumulator: hand-computed Booth products,
// handshake stalls, illegal digits, async reset mid-product, ignored starts.
module tb_booth_digit_accumulator;

  localparam logic [2:0] Z   = 3'b000; // {neg,one,two}
  localparam logic [2:0] P1  = 3'b010;
  localparam logic [2:0] P2  = 3'b001;
  localparam logic [2:0] N2  = 3'b101;
  localparam logic [2:0] ILL = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] multiplicand = '0;
  logic        dig_valid = 1'b0;
  logic        dig_neg = 1'b0, dig_one = 1'b0, dig_two = 1'b0;
  logic        dig_ready, busy, done, err;
  logic [31:0] product;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_digit_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(multiplicand),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_neg(dig_neg),
    .dig_one(dig_one), .dig_two(dig_two), .busy(busy), .done(done),
    .err(err), .product(product)
  );

  // Runs one product from a negedge. Cycle 0 is the start cycle; done_cyc is
  // the cycle offset at which done is seen (-1 on timeout). Optionally pulses
  // start with another M at cycle start_at while busy.
  task automatic drive_product(input logic [15:0] m, input logic [2:0] d [8],
                               input bit alt, input int start_at,
                               input logic [15:0] m_alt, output int done_cyc,
                               output int ready_bad, output int busy_bad);
    int i = 0;
    int cyc = 0;
    bit ph = 1'b1;
    ready_bad = 0;
    busy_bad  = 0;
    done_cyc  = -1;
    @(negedge clk);
    if (dig_ready !== 1'b0) ready_bad++;
    if (busy !== 1'b0) busy_bad++;
    start = 1'b1;
    multiplicand = m;
    @(negedge clk);
    cyc = 1;
    while (cyc < 60 && done_cyc < 0) begin
      start = (cyc == start_at);
      if (cyc == start_at) multiplicand = m_alt;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        if (dig_ready !== 1'b0) ready_bad++;
        dig_valid = 1'b0;
      end else if (i < 8) begin
        dig_valid = alt ? ph : 1'b1;
        ph = ~ph;
        {dig_neg, dig_one, dig_two} = d[i];
        if (dig_valid && dig_ready) i++;
      end else begin
        dig_valid = 1'b0;
      end
      if (done_cyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    dig_valid = 1'b0;
    {dig_neg, dig_one, dig_two} = Z;
  endtask

  task automatic test_reset();
    #1;
    total++; if (product !== 32'd0) begin bad++; $display("FAIL reset_product: got %h want 0", product); end
    total++; if ({busy, done, err, dig_ready} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, dig_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [2:0] d [8] = '{P1, N2, P1, Z, Z, Z, Z, Z};
    int dc, rb, bb;
    drive_product(16'd3, d, 1'b0, -1, 16'd0, dc, rb, bb);
    total++; if (dc !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", dc); end
    total++; if (product !== 32'h0000001B) begin bad++; $display("FAIL basic_product: got %h want 0000001b", product); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err); end
    total++; if (rb !== 0 || bb !== 0) begin bad++; $display("FAIL basic_handshake: ready_bad %0d busy_bad %0d want 0 0", rb, bb); end
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL basic_done_pulse: done,busy got %b want 00", {done, busy}); end
    total++; if (product !== 32'h0000001B) begin bad++; $display("FAIL basic_hold: got %h want 0000001b", product); end
  endtask

  task automatic test_min_neg();
    logic [2:0] d [8] = '{Z, Z, Z, Z, Z, Z, Z, N2};
    int dc, rb, bb;
    // -32768 * -2 * 4^7 = 2^30
    drive_product(16'h8000, d, 1'b0, -1, 16'd0, dc, rb, bb);
    total++; if (product !== 32'h40000000) begin bad++; $display("FAIL minneg_product: got %h want 40000000", product); end
  endtask

  task automatic test_stall();
    logic [2:0] d [8] = '{P1, P1, P1, P1, P1, P1, P1, P1};
    int dc, rb, bb;
    // multiplier = sum 4^i = 21845; -5 * 21845 = -109225
    drive_product(16'hFFFB, d, 1'b0, -1, 16'd0, dc, rb, bb);
    total++; if (product !== 32'hFFFE5557) begin bad++; $display("FAIL neg_product: got %h want fffe5557", product); end
    drive_product(16'hFFFB, d, 1'b1, -1, 16'd0, dc, rb, bb);
    total++; if (product !== 32'hFFFE5557) begin bad++; $display("FAIL stall_product: got %h want fffe5557", product); end
    // transfers on cycles 1,3,..,15; done one cycle after the last
    total++; if (dc !== 16) begin bad++; $display("FAIL stall_latency: got %0d want 16", dc); end
    total++; if (rb !== 0 || bb !== 0) begin bad++; $display("FAIL stall_handshake: ready_bad %0d busy_bad %0d want 0 0", rb, bb); end
  endtask

  task automatic test_illegal();
    logic [2:0] d [8]  = '{P2, Z, ILL, Z, Z, Z, Z, Z};
    logic [2:0] d2 [8] = '{P1, N2, P1, Z, Z, Z, Z, Z};
    int dc, rb, bb;
    drive_product(16'd7, d, 1'b0, -1, 16'd0, dc, rb, bb);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err: got %b want 1", err); end
    total++; if (product !== 32'd14) begin bad++; $display("FAIL illegal_product: got %h want 0000000e", product); end
    total++; if (dc !== 9) begin bad++; $display("FAIL illegal_latency: got %0d want 9", dc); end
    drive_product(16'd3, d2, 1'b0, -1, 16'd0, dc, rb, bb);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_clear: got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] d [8] = '{P1, N2, P1, Z, Z, Z, Z, Z};
    int dc, rb, bb;
    int seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    multiplicand = 16'd3;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dig_valid = 1'b1;
      {dig_neg, dig_one, dig_two} = d[k];
      @(negedge clk);
    end
    dig_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (product !== 32'd0) begin bad++; $display("FAIL rstmid_product: got %h want 0", product); end
    total++; if ({busy, done, err, dig_ready} !== 4'b0) begin bad++; $display("FAIL rstmid_flags: got %b want 0000", {busy, done, err, dig_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", seen_done); end
    drive_product(16'd3, d, 1'b0, -1, 16'd0, dc, rb, bb);
    total++; if (product !== 32'h0000001B) begin bad++; $display("FAIL rstmid_restart: got %h want 0000001b", product); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] d [8] = '{P1, N2, P1, Z, Z, Z, Z, Z};
    int dc, rb, bb;
    drive_product(16'd3, d, 1'b0, 3, 16'd100, dc, rb, bb);
    total++; if (product !== 32'h0000001B) begin bad++; $display("FAIL start_ignored: got %h want 0000001b", product); end
    total++; if (dc !== 9) begin bad++; $display("FAIL start_ignored_latency: got %0d want 9", dc); end
    // start during DONE is dropped
    start = 1'b1;
    multiplicand = 16'd5;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_start_ignored: busy got %b want 0", busy); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL done_start_idle: busy,done got %b want 00", {busy, done}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_neg();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
